// File: rtl/fft_iter_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_iter_addr_gen
//
// Butterfly address generator for an iterative in-place radix-2 DIT FFT.
// Follows the FFT control unit and acts on its ADDR_RST / ADDR_EN / LAY_EN
// strobes. It tracks the layer index s and the butterfly index j. For
// butterfly (s,j) it produces the two data-RAM addresses and the twiddle-ROM
// index.
//
// Address mapping, with half = 2^s and k = j mod half:
//   ADDR_A  = j with a 0 bit inserted at bit position s
//   ADDR_B  = ADDR_A with that inserted bit set to 1 (ADDR_A + half)
//   TW_ADDR = k << (LAYERS-1-s)
//
// Every output is registered. Outputs are computed from the next-state j/s,
// so they change on the same edge as the indices.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   EN         in   global clock enable; RST is the only thing it does not gate
//   ADDR_RST   in   clears j, s and LAY_OVF; has priority over the strobes
//   ADDR_EN    in   advance butterfly index j (wraps silently)
//   LAY_EN     in   advance layer index s (saturates at LAYERS-1)
//   ADDR_A     out  upper-wing data address
//   ADDR_B     out  lower-wing data address
//   TW_ADDR    out  twiddle ROM index
//   LAY_IDX    out  current layer s
//   BUT_IDX    out  current butterfly j
//   LAST_LAY   out  high while s == LAYERS-1
//   LAY_OVF    out  sticky; set by LAY_EN arriving on the last layer
//
// Optional feature, enabled by the macro FFT_ADDR_BITREV_LOAD_EN:
//   LOAD_EN    in   load strobe for the bit-reverse register
//   LOAD_IDX   in   natural-order sample index
//   LOAD_ADDR  out  registered bit-reversal of LOAD_IDX (0 after RST)
// When the macro is undefined, these ports and their logic are not present.
// -----------------------------------------------------------------------------
module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                ADDR_RST,
  input  logic                ADDR_EN,
  input  logic                LAY_EN,
`ifdef FFT_ADDR_BITREV_LOAD_EN
  input  logic                LOAD_EN,
  input  logic [LAYERS-1:0]   LOAD_IDX,
  output logic [LAYERS-1:0]   LOAD_ADDR,
`endif
  output logic [LAYERS-1:0]   ADDR_A,
  output logic [LAYERS-1:0]   ADDR_B,
  output logic [LAYERS-2:0]   TW_ADDR,
  output logic [LayWL-1:0]    LAY_IDX,
  output logic [ButtWL-1:0]   BUT_IDX,
  output logic                LAST_LAY,
  output logic                LAY_OVF
);

  // Index state
  logic [ButtWL-1:0] j_q, j_d;
  logic [LayWL-1:0]  s_q, s_d;
  logic              ovf_q, ovf_d;

  // Registered outputs
  logic [LAYERS-1:0] addr_a_q, addr_a_d;
  logic [LAYERS-1:0] addr_b_q, addr_b_d;
  logic [LAYERS-2:0] tw_q, tw_d;
  logic              last_q, last_d;

  // ---------------------------------------------------------------------------
  // Next-state indices
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of always_comb. Without a
  // value on every path, synthesis infers a latch.
  always_comb begin
    j_d   = j_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    if (ADDR_RST) begin
      j_d   = '0;
      s_d   = '0;
      ovf_d = 1'b0;
    end else begin
      if (ADDR_EN) begin
        j_d = (j_q == ButtWL'(BUTTERFLYES - 1)) ? '0 : j_q + ButtWL'(1);
      end
      if (LAY_EN) begin
        if (s_q == LayWL'(LAYERS - 1)) begin
          ovf_d = 1'b1;
        end else begin
          s_d = s_q + LayWL'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-layer candidate addresses, built by bit insertion on j_d.
  // This relies on ButtWL == LAYERS-1, so j plus the inserted bit fills the
  // address width exactly.
  // ---------------------------------------------------------------------------
  logic [LAYERS-1:0] cand_a  [LAYERS];
  logic [LAYERS-1:0] cand_b  [LAYERS];
  logic [LAYERS-2:0] cand_tw [LAYERS];

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_lay
    if (gi == 0) begin : g_first
      // half = 1: adjacent pair, k is always 0
      assign cand_a[gi]  = {j_d, 1'b0};
      assign cand_b[gi]  = {j_d, 1'b1};
      assign cand_tw[gi] = '0;
    end else if (gi == LAYERS - 1) begin : g_last
      // g is always 0 and k == j; the twiddle index is not shifted
      assign cand_a[gi]  = {1'b0, j_d};
      assign cand_b[gi]  = {1'b1, j_d};
      assign cand_tw[gi] = j_d;
    end else begin : g_mid
      assign cand_a[gi]  = {j_d[ButtWL-1:gi], 1'b0, j_d[gi-1:0]};
      assign cand_b[gi]  = {j_d[ButtWL-1:gi], 1'b1, j_d[gi-1:0]};
      assign cand_tw[gi] = {j_d[gi-1:0], {(LAYERS-1-gi){1'b0}}};
    end
  end

  // Select by next layer. s_d never exceeds LAYERS-1.
  always_comb begin
    addr_a_d = cand_a[0];
    addr_b_d = cand_b[0];
    tw_d     = cand_tw[0];
    for (int i = 1; i < LAYERS; i++) begin
      if (s_d == LayWL'(i)) begin
        addr_a_d = cand_a[i];
        addr_b_d = cand_b[i];
        tw_d     = cand_tw[i];
      end
    end
    last_d = (s_d == LayWL'(LAYERS - 1));
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments. All
  // registers then sample their inputs from before the edge, which removes any
  // dependence on evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      j_q      <= '0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= LAYERS'(1);
      tw_q     <= '0;
      last_q   <= 1'b0;
    end else if (EN) begin
      j_q      <= j_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      last_q   <= last_d;
    end
  end

  assign ADDR_A   = addr_a_q;
  assign ADDR_B   = addr_b_q;
  assign TW_ADDR  = tw_q;
  assign LAY_IDX  = s_q;
  assign BUT_IDX  = j_q;
  assign LAST_LAY = last_q;
  assign LAY_OVF  = ovf_q;

`ifdef FFT_ADDR_BITREV_LOAD_EN
  // Bit-reversed write address for loading natural-order input samples
  logic [LAYERS-1:0] load_addr_q, load_addr_d;

  always_comb begin
    load_addr_d = '0;
    for (int i = 0; i < LAYERS; i++) begin
      load_addr_d[i] = LOAD_IDX[LAYERS-1-i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_addr_q <= '0;
    end else if (EN && LOAD_EN) begin
      load_addr_q <= load_addr_d;
    end
  end

  assign LOAD_ADDR = load_addr_q;
`endif

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_iter_addr_gen
//
// Scoreboard bench for fft_iter_addr_gen (LAYERS=5). The driver applies one
// set of inputs per cycle. After a cycle whose result matters, it pushes the
// hand-computed output set, tagged with the clock edge that produces it. A
// separate monitor samples on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_fft_iter_addr_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       ADDR_RST = 1'b0;
  logic       ADDR_EN = 1'b0;
  logic       LAY_EN = 1'b0;
  logic [4:0] ADDR_A, ADDR_B;
  logic [3:0] TW_ADDR;
  logic [2:0] LAY_IDX;
  logic [3:0] BUT_IDX;
  logic       LAST_LAY, LAY_OVF;
`ifdef FFT_ADDR_BITREV_LOAD_EN
  logic       LOAD_EN = 1'b0;
  logic [4:0] LOAD_IDX = '0;
  logic [4:0] LOAD_ADDR;
`endif

  fft_iter_addr_gen dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .ADDR_RST (ADDR_RST),
    .ADDR_EN  (ADDR_EN),
    .LAY_EN   (LAY_EN),
`ifdef FFT_ADDR_BITREV_LOAD_EN
    .LOAD_EN  (LOAD_EN),
    .LOAD_IDX (LOAD_IDX),
    .LOAD_ADDR(LOAD_ADDR),
`endif
    .ADDR_A   (ADDR_A),
    .ADDR_B   (ADDR_B),
    .TW_ADDR  (TW_ADDR),
    .LAY_IDX  (LAY_IDX),
    .BUT_IDX  (BUT_IDX),
    .LAST_LAY (LAST_LAY),
    .LAY_OVF  (LAY_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    due;
    string name;
    int    a, b, tw, lay, but, last, ovf, ld;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each expectation on the falling edge after its clock edge
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".due"}, e.due, cyc);
      check({e.name, ".ADDR_A"},   int'(ADDR_A),   e.a);
      check({e.name, ".ADDR_B"},   int'(ADDR_B),   e.b);
      check({e.name, ".TW_ADDR"},  int'(TW_ADDR),  e.tw);
      check({e.name, ".LAY_IDX"},  int'(LAY_IDX),  e.lay);
      check({e.name, ".BUT_IDX"},  int'(BUT_IDX),  e.but);
      check({e.name, ".LAST_LAY"}, int'(LAST_LAY), e.last);
      check({e.name, ".LAY_OVF"},  int'(LAY_OVF),  e.ovf);
`ifdef FFT_ADDR_BITREV_LOAD_EN
      check({e.name, ".LOAD_ADDR"}, int'(LOAD_ADDR), e.ld);
`endif
    end
  end

  // Drive one cycle of inputs, just after a rising edge. The next edge samples them.
  task automatic apply(input bit rst, input bit en, input bit arst,
                       input bit aen, input bit len);
    @(posedge CLK);
    #1;
    RST      = rst;
    EN       = en;
    ADDR_RST = arst;
    ADDR_EN  = aen;
    LAY_EN   = len;
  endtask

  // Expected outputs after the edge that samples the inputs just applied
  task automatic expect_o(input string name, input int a, input int b,
                          input int tw, input int lay, input int but,
                          input int last, input int ovf, input int ld = 0);
    exp_t e;
    e.due = cyc + 1;
    e.name = name;
    e.a = a; e.b = b; e.tw = tw; e.lay = lay; e.but = but;
    e.last = last; e.ovf = ovf; e.ld = ld;
    q.push_back(e);
  endtask

  initial begin
    // 1: reset
    apply(1, 1, 0, 0, 0);
    expect_o("rst", 0, 1, 0, 0, 0, 0, 0);

    // 2: layer 0, sixteen butterflies, then wrap
    for (int p = 1; p <= 16; p++) begin
      apply(0, 1, 0, 1, 0);
      expect_o($sformatf("l0_p%0d", p), 2 * (p % 16), 2 * (p % 16) + 1, 0, 0, p % 16, 0, 0);
    end

    // 3: walk to s=2 j=5, then s=3, s=4, and j=15 on the last layer
    apply(0, 1, 0, 0, 1);
    apply(0, 1, 0, 0, 1);
    expect_o("s2_j0", 0, 4, 0, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 1, 0);
    expect_o("s2_j5", 9, 13, 4, 2, 5, 0, 0);
    apply(0, 1, 0, 0, 1);
    expect_o("s3_j5", 5, 13, 10, 3, 5, 0, 0);
    apply(0, 1, 0, 0, 1);
    expect_o("s4_j5", 5, 21, 5, 4, 5, 1, 0);
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 1, 0);
    expect_o("s4_j15", 15, 31, 15, 4, 15, 1, 0);

    // 4: overflow on the last layer, sticky until ADDR_RST
    apply(0, 1, 0, 0, 1);
    expect_o("ovf_set", 15, 31, 15, 4, 15, 1, 1);
    apply(0, 1, 0, 1, 0);
    expect_o("ovf_sticky", 0, 16, 0, 4, 0, 1, 1);
    apply(0, 1, 1, 0, 0);
    expect_o("ovf_clr", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) apply(0, 1, 0, 1, 0);
    expect_o("s0_j15", 30, 31, 0, 0, 15, 0, 0);
    apply(0, 1, 0, 1, 1);
    expect_o("both_strobes", 0, 2, 0, 1, 0, 0, 0);

    // 5: enable gating, mid-layer ADDR_RST, reset precedence
    for (int i = 0; i < 7; i++) apply(0, 1, 0, 1, 0);
    expect_o("s1_j7", 13, 15, 8, 1, 7, 0, 0);
    apply(0, 1, 0, 0, 1);
    apply(0, 1, 0, 0, 1);
    expect_o("s3_j7", 7, 15, 14, 3, 7, 0, 0);
    apply(0, 0, 1, 1, 1);
    expect_o("en0_all", 7, 15, 14, 3, 7, 0, 0);
    apply(0, 0, 0, 1, 1);
    expect_o("en0_strb", 7, 15, 14, 3, 7, 0, 0);
    apply(0, 1, 1, 0, 0);
    expect_o("arst_mid", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 1);
    expect_o("s1_j1", 1, 3, 8, 1, 1, 0, 0);
    apply(1, 0, 0, 1, 1);
    expect_o("rst_en0", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 1);
    apply(1, 1, 1, 1, 1);
    expect_o("rst_arst", 0, 1, 0, 0, 0, 0, 0);

`ifdef FFT_ADDR_BITREV_LOAD_EN
    // 6: bit-reversed load addresses
    apply(0, 1, 0, 0, 0); LOAD_EN = 1'b1; LOAD_IDX = 5'd1;
    expect_o("brev_1", 0, 1, 0, 0, 0, 0, 0, 16);
    apply(0, 1, 0, 0, 0); LOAD_EN = 1'b1; LOAD_IDX = 5'd6;
    expect_o("brev_6", 0, 1, 0, 0, 0, 0, 0, 12);
    apply(0, 1, 0, 0, 0); LOAD_EN = 1'b1; LOAD_IDX = 5'd31;
    expect_o("brev_31", 0, 1, 0, 0, 0, 0, 0, 31);
    apply(0, 1, 0, 0, 0); LOAD_EN = 1'b0; LOAD_IDX = 5'd3;
    expect_o("brev_hold", 0, 1, 0, 0, 0, 0, 0, 31);
    apply(0, 0, 0, 0, 0); LOAD_EN = 1'b1; LOAD_IDX = 5'd2;
    expect_o("brev_en0", 0, 1, 0, 0, 0, 0, 0, 31);
`endif

    // Idle, then drain the scoreboard within a bounded number of cycles
    apply(0, 1, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
